// File: rtl/encoder_pkg.sv
// Shared widths and types for the registered 8-to-3 encoder.
// Also hosts a small popcount helper used by the one-hot checker.
package encoder_pkg;

    localparam int ENC_IN_W  = 8;
    localparam int ENC_OUT_W = 3;

    typedef logic [ENC_IN_W-1:0]  enc_in_t;
    typedef logic [ENC_OUT_W-1:0] enc_idx_t;

    // Number of set bits in a request vector (0..8)
    function automatic logic [3:0] enc_popcnt(input enc_in_t v);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < ENC_IN_W; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/encoder_8to3_core.sv
// Combinational priority encoder: highest set bit wins, bit 7 first.
// One-hot checker compiled in only with ENCODER_8TO3_ONEHOT_CHECK_EN.
module encoder_8to3_core
    import encoder_pkg::*;
(
    input  logic [7:0] i_in,
    output logic [2:0] o_idx,
    output logic       o_any,
    output logic       o_onehot_err
);

    enc_idx_t w_idx;

    // Ascending scan so the highest set bit overwrites lower ones
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < ENC_IN_W; i++) begin
            if (i_in[i]) begin
                w_idx = ENC_OUT_W'(i);
            end
        end
    end

    assign o_idx = w_idx;
    assign o_any = |i_in;

`ifdef ENCODER_8TO3_ONEHOT_CHECK_EN
    assign o_onehot_err = (enc_popcnt(i_in) != 4'd1);
`else
    assign o_onehot_err = 1'b0;
`endif

endmodule

// File: rtl/encoder_8to3.sv
// Registered 8-to-3 encoder with sample enable and synchronous reset.
// err is live only with ENCODER_8TO3_ONEHOT_CHECK_EN, else constant 0.
module encoder_8to3
    import encoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] in,
    output logic [2:0] out,
    output logic       valid,
    output logic       err
);

    enc_idx_t w_idx;
    logic     w_any;
    logic     w_onehot_err;

    enc_idx_t r_out;
    logic     r_valid;

    encoder_8to3_core u_core (
        .i_in         (in),
        .o_idx        (w_idx),
        .o_any        (w_any),
        .o_onehot_err (w_onehot_err)
    );

    // Capture index and valid on enabled edges; reset wins over enable
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else if (en) begin
            r_out   <= w_idx;
            r_valid <= w_any;
        end
    end

    assign out   = r_out;
    assign valid = r_valid;

`ifdef ENCODER_8TO3_ONEHOT_CHECK_EN
    logic r_err;

    // Capture the one-hot violation alongside the index
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (en) begin
            r_err <= w_onehot_err;
        end
    end

    assign err = r_err;
`else
    // Core drives a constant 0 here, so no register is built
    assign err = w_onehot_err;
`endif

endmodule

// File: tb/tb_encoder_8to3.sv
// Self-checking bench for encoder_8to3 against a behavioural model.
// Expected err follows ENCODER_8TO3_ONEHOT_CHECK_EN like the design.
module tb_encoder_8to3;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] in;
    logic [2:0] out;
    logic       valid;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0] m_out;
    logic       m_valid;
    logic       m_err;

    encoder_8to3 dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .in    (in),
        .out   (out),
        .valid (valid),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // floor(log2(v)) for nonzero v, 0 for zero
    function automatic int hi_idx(input logic [7:0] v);
        int k;
        int x;
        k = 0;
        x = int'(v);
        while (x > 1) begin
            x = x / 2;
            k++;
        end
        return k;
    endfunction

    function automatic int ones(input logic [7:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 8; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic logic exp_err(input logic [7:0] v);
`ifdef ENCODER_8TO3_ONEHOT_CHECK_EN
        return ones(v) != 1;
`else
        return (v === 8'hxx);
`endif
    endfunction

    // Apply one cycle of stimulus and advance the reference model
    task automatic drive(input logic r, input logic e, input logic [7:0] v);
        @(negedge clk);
        rst = r;
        en  = e;
        in  = v;
        @(posedge clk);
        #1;
        if (r) begin
            m_out   = 3'd0;
            m_valid = 1'b0;
            m_err   = 1'b0;
        end else if (e) begin
            m_out   = 3'(hi_idx(v));
            m_valid = (v != 8'd0);
            m_err   = exp_err(v);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 8'h80);
            n_cmp++;
            if (out !== 3'd0 || valid !== 1'b0 || err !== 1'b0) begin
                n_bad++;
                $display("FAIL reset: got out=%0d valid=%b err=%b want 0/0/0",
                         out, valid, err);
            end
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 8'(1 << i));
            n_cmp++;
            if (out !== 3'(i) || valid !== 1'b1 || err !== 1'b0) begin
                n_bad++;
                $display("FAIL sweep%0d: got out=%0d valid=%b err=%b want %0d/1/0",
                         i, out, valid, err, i);
            end
        end
    endtask

    task automatic test_multihot();
        drive(1'b0, 1'b1, 8'b0010_0110);
        n_cmp++;
        if (out !== 3'd5 || valid !== 1'b1 || err !== m_err) begin
            n_bad++;
            $display("FAIL multihot26: got out=%0d valid=%b err=%b want 5/1/%b",
                     out, valid, err, m_err);
        end
        drive(1'b0, 1'b1, 8'hFF);
        n_cmp++;
        if (out !== 3'd7 || valid !== 1'b1 || err !== m_err) begin
            n_bad++;
            $display("FAIL multihotFF: got out=%0d valid=%b err=%b want 7/1/%b",
                     out, valid, err, m_err);
        end
    endtask

    task automatic test_zero();
        drive(1'b0, 1'b1, 8'h00);
        n_cmp++;
        if (out !== 3'd0 || valid !== 1'b0 || err !== m_err) begin
            n_bad++;
            $display("FAIL zero: got out=%0d valid=%b err=%b want 0/0/%b",
                     out, valid, err, m_err);
        end
    endtask

    task automatic test_enable_hold();
        drive(1'b0, 1'b1, 8'h08);
        n_cmp++;
        if (out !== 3'd3 || valid !== 1'b1 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_load: got out=%0d valid=%b err=%b want 3/1/0",
                     out, valid, err);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 8'h40);
            n_cmp++;
            if (out !== 3'd3 || valid !== 1'b1 || err !== 1'b0) begin
                n_bad++;
                $display("FAIL hold%0d: got out=%0d valid=%b err=%b want 3/1/0",
                         i, out, valid, err);
            end
        end
        drive(1'b0, 1'b1, 8'h40);
        n_cmp++;
        if (out !== 3'd6) begin
            n_bad++;
            $display("FAIL hold_release: got out=%0d want 6", out);
        end
        // Hold a zero-input result too, so err/valid hold is exercised
        drive(1'b0, 1'b1, 8'h00);
        drive(1'b0, 1'b0, 8'h01);
        n_cmp++;
        if (out !== 3'd0 || valid !== 1'b0 || err !== m_err) begin
            n_bad++;
            $display("FAIL hold_zero: got out=%0d valid=%b err=%b want 0/0/%b",
                     out, valid, err, m_err);
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'(1 << i));
        drive(1'b1, 1'b1, 8'h10);
        n_cmp++;
        if (out !== 3'd0 || valid !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset: got out=%0d valid=%b err=%b want 0/0/0",
                     out, valid, err);
        end
        drive(1'b0, 1'b1, 8'h20);
        n_cmp++;
        if (out !== 3'd5 || valid !== 1'b1 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL postreset: got out=%0d valid=%b err=%b want 5/1/0",
                     out, valid, err);
        end
    endtask

    task automatic test_random();
        logic       r;
        logic       e;
        logic [7:0] v;
        for (int n = 0; n < 300; n++) begin
            r = ($urandom_range(0, 15) == 0);
            e = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0:       v = 8'(1 << $urandom_range(0, 7));
                1:       v = 8'($urandom);
                default: v = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            endcase
            drive(r, e, v);
            n_cmp++;
            if (out !== m_out || valid !== m_valid || err !== m_err) begin
                n_bad++;
                $display("FAIL random%0d: in=%h rst=%b en=%b got %0d/%b/%b want %0d/%b/%b",
                         n, v, r, e, out, valid, err, m_out, m_valid, m_err);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        in      = 8'h00;
        m_out   = 3'd0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        test_reset();
        test_sweep();
        test_multihot();
        test_zero();
        test_enable_hold();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
